serial_io_bridge: RTL and testbench
===================================

// Module: serial_io_bridge
// PURPOSE
//  Parametrised serial-to-parallel harness that lets a 3-pin host (din/stb/dout) drive a wide DUT.
//  - din shifts into an input shift register.
//  - stb commits it to the DUT inputs (par_out), then captures the DUT outputs (par_in) into an output shift register that streams back on dout.
//  - Adds over the fixed-width wrapper: configurable widths, programmable capture delay, busy handshake and short-frame detection.
//  - Sits between top-level pins and any wide core under test.
// PARAMETERS
//  DIN_W        34  DUT input width / input shift register length (>=2)
//  DOUT_W       71  DUT output width / output shift register length (>=2)
//  CAPTURE_DLY  0   cycles from UPDATE to capture of par_in; 0 = capture in the update cycle (legacy)
//  CNT_W        8   width of shift counter (and of frame_cnt when enabled)
// PORTS
//  clk        in   1       sole clock, rising edge
//  rst        in   1       synchronous reset, active-high
//  din        in   1       serial data in
//  stb        in   1       update/capture strobe (level, sampled per cycle)
//  dout       out  1       serial data out = dout_shr[DOUT_W-1]
//  par_out    out  DIN_W   parallel drive to DUT inputs
//  par_in     in   DOUT_W  parallel DUT outputs
//  busy       out  1       high while an update/capture sequence is in flight
//  upd_pulse  out  1       one-cycle pulse, cycle after par_out changes
//  short_err  out  1       last update had fewer than DIN_W shifts since the previous update
//  frame_cnt  out  CNT_W   completed captures, wraps (only with SERIAL_IO_BRIDGE_FRAME_CNT_EN)
// BEHAVIOUR
//  - Reset: din_shr, dout_shr, par_out, shift_cnt, dly_cnt, frame_cnt = 0. busy, upd_pulse, short_err = 0. State IDLE.
//  - States:
//    - IDLE, stb=0, busy=0 (shift): din_shr <= {din_shr[DIN_W-2:0],din}.
//      dout_shr <= {dout_shr[DOUT_W-2:0],din_shr[DIN_W-1]}. shift_cnt +1, saturating at 2^CNT_W-1.
//    - IDLE, stb=1: par_out <= din_shr. short_err <= (shift_cnt < DIN_W). shift_cnt <= 0. No shift this cycle.
//      - CAPTURE_DLY=0: dout_shr <= par_in in the same cycle (DUT pre-update response); stay IDLE.
//      - CAPTURE_DLY>0: dly_cnt <= CAPTURE_DLY-1; go to WAIT.
//    - WAIT: busy=1. Decrement dly_cnt. At 0: dout_shr <= par_in; go to IDLE. Capture occurs exactly CAPTURE_DLY cycles after the update edge.
//  - busy is combinational (state==WAIT). During WAIT, din and stb are ignored: no shift, no re-trigger.
//  - stb held high in IDLE re-updates every cycle (idempotent par_out, repeated capture). Host must pulse.
//  - upd_pulse registered: high for the one cycle following each update edge.
//  - Reset mid-WAIT: aborts the sequence; no capture; all state to reset values.
//  - Wrap: frame_cnt increments on each capture, modulo 2^CNT_W.
//  - Latency: par_out valid 1 cycle after stb sample. First dout bit of the captured frame is visible 1 cycle after the capture edge.
// CONFIGURATION
//  SERIAL_IO_BRIDGE_FRAME_CNT_EN
//  - defined: frame_cnt port and counter are present.
//  - undefined: port and counter are absent; all other behaviour identical.
// STRUCTURE
//  - Package serial_io_bridge_pkg: state enum {IDLE, WAIT}; helper function clog2-based dly_cnt width.
//  - Sub-module sio_shreg (W param; load, shift, sin, q): used twice, for din_shr and dout_shr.
//  - FSM, counters and flags stay in top.
// TESTING  (DIN_W=4, DOUT_W=6, CAPTURE_DLY=2, CNT_W=4 unless noted)
//  1 Reset: assert rst 2 cycles -> par_out=0, dout=0, busy=0, short_err=0, upd_pulse=0.
//  2 Shift din 1,0,1,1 then stb -> par_out=4'b1011, short_err=0, upd_pulse next cycle, busy 2 cycles.
//    par_in=6'h2A is captured at the 2nd WAIT edge. Next 6 shifts give dout=1,0,1,0,1,0.
//  3 Shift only 2 bits then stb -> short_err=1. Following full 4-bit frame -> short_err=0.
//  4 Toggle din and pulse stb during WAIT -> din_shr and dout_shr unchanged; no second update.
//  5 rst at first WAIT cycle -> no capture; dout_shr=0, busy=0.
//    With FRAME_CNT_EN: frame_cnt not incremented.
//  6 CAPTURE_DLY=0: stb with par_in=6'h15 -> capture same edge as update, busy never high.
//    With FRAME_CNT_EN: 16 frames -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/serial_io_bridge_pkg.sv
// -----------------------------------------------------------------------------
// serial_io_bridge_pkg
// Shared types and helpers for the serial I/O bridge.
//   state_t        : bridge sequencer states (IDLE, WAIT)
//   dly_cnt_width  : width of the capture-delay down-counter for a given delay
// -----------------------------------------------------------------------------
package serial_io_bridge_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   // The counter is loaded with dly-1 and counts down to 0, so it only has to
   // hold values up to dly-1. Keep at least one bit so the vector is legal
   // when the delay feature is unused (dly = 0 or 1).
   function automatic int dly_cnt_width(input int dly);
      return (dly > 1) ? $clog2(dly) : 1;
   endfunction

endpackage

// File: rtl/sio_shreg.sv
// -----------------------------------------------------------------------------
// sio_shreg
// Parallel-load, left-shifting register (MSB leaves first).
// Ports:
//   clk   in  1  rising-edge clock
//   rst   in  1  synchronous reset, active-high (clears q)
//   load  in  1  load d into q (wins over shift)
//   d     in  W  parallel load value
//   shift in  1  shift q left by one, sin enters at bit 0
//   sin   in  1  serial input
//   q     out W  register contents
// -----------------------------------------------------------------------------
module sio_shreg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] d,
   input  logic         shift,
   input  logic         sin,
   output logic [W-1:0] q
);

   logic [W-1:0] q_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         q_reg <= '0;
      end else if (load) begin
         q_reg <= d;
      end else if (shift) begin
         q_reg <= {q_reg[W-2:0], sin};
      end
   end

   assign q = q_reg;

endmodule

// File: rtl/serial_io_bridge.sv
// -----------------------------------------------------------------------------
// serial_io_bridge
// Serial-to-parallel harness letting a 3-pin host (din/stb/dout) drive a wide
// core. Bits on din shift into an input register; stb commits that register to
// par_out and captures par_in (immediately, or CAPTURE_DLY cycles later) into
// an output register that streams back on dout, MSB first.
//
// Optional feature macro: SERIAL_IO_BRIDGE_FRAME_CNT_EN
//   defined   : frame_cnt port and capture counter are present
//   undefined : no frame_cnt port; everything else identical
//
// Ports:
//   clk        in   1       sole clock, rising edge
//   rst        in   1       synchronous reset, active-high
//   din        in   1       serial data in
//   stb        in   1       update/capture strobe (level, sampled per cycle)
//   dout       out  1       serial data out (output register MSB)
//   par_out    out  DIN_W   parallel drive to core inputs
//   par_in     in   DOUT_W  parallel core outputs
//   busy       out  1       high while waiting for a delayed capture
//   upd_pulse  out  1       one-cycle pulse in the cycle after an update
//   short_err  out  1       last update saw fewer than DIN_W shifts
//   frame_cnt  out  CNT_W   completed captures, wrapping (macro only)
// -----------------------------------------------------------------------------
module serial_io_bridge
   import serial_io_bridge_pkg::*;
#(
   parameter int DIN_W       = 34,
   parameter int DOUT_W      = 71,
   parameter int CAPTURE_DLY = 0,
   parameter int CNT_W       = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              din,
   input  logic              stb,
   output logic              dout,
   output logic [DIN_W-1:0]  par_out,
   input  logic [DOUT_W-1:0] par_in,
   output logic              busy,
   output logic              upd_pulse,
   output logic              short_err
`ifdef SERIAL_IO_BRIDGE_FRAME_CNT_EN
   ,
   output logic [CNT_W-1:0]  frame_cnt
`endif
);

   localparam int DLY_W = dly_cnt_width(CAPTURE_DLY);
   localparam logic [DLY_W-1:0] DLY_LOAD =
      (CAPTURE_DLY > 0) ? DLY_W'(CAPTURE_DLY - 1) : '0;

   state_t            state_reg, state_next;
   logic [DLY_W-1:0]  dly_cnt_reg, dly_cnt_next;
   logic [CNT_W-1:0]  shift_cnt_reg;
   logic [DIN_W-1:0]  par_out_reg;
   logic              upd_pulse_reg;
   logic              short_err_reg;

   logic              shift_en;
   logic              update;
   logic              capture;

   logic [DIN_W-1:0]  din_shr;
   logic [DOUT_W-1:0] dout_shr;

   // -------------------------------------------------------------------------
   // Shift registers
   // -------------------------------------------------------------------------
   sio_shreg #(.W(DIN_W)) u_din_shr (
      .clk   (clk),
      .rst   (rst),
      .load  (1'b0),
      .d     ({DIN_W{1'b0}}),
      .shift (shift_en),
      .sin   (din),
      .q     (din_shr)
   );

   // The output chain is fed from the input chain's MSB so a continuous
   // stream keeps flowing host -> din_shr -> dout_shr -> host.
   sio_shreg #(.W(DOUT_W)) u_dout_shr (
      .clk   (clk),
      .rst   (rst),
      .load  (capture),
      .d     (par_in),
      .shift (shift_en),
      .sin   (din_shr[DIN_W-1]),
      .q     (dout_shr)
   );

   // Only the MSB leaves the block; the lower bits live purely inside the
   // shift chain.
   logic dout_shr_low_unused;
   assign dout_shr_low_unused = ^dout_shr[DOUT_W-2:0];

   // -------------------------------------------------------------------------
   // Sequencer: next state and per-cycle actions
   // -------------------------------------------------------------------------
   always_comb begin
      state_next   = state_reg;
      dly_cnt_next = dly_cnt_reg;
      shift_en     = 1'b0;
      update       = 1'b0;
      capture      = 1'b0;

      case (state_reg)
         IDLE: begin
            if (stb) begin
               update = 1'b1;
               if (CAPTURE_DLY == 0) begin
                  // Legacy mode: the core's response to the old inputs is
                  // sampled on the very edge that applies the new ones.
                  capture = 1'b1;
               end else begin
                  dly_cnt_next = DLY_LOAD;
                  state_next   = WAIT;
               end
            end else begin
               shift_en = 1'b1;
            end
         end
         WAIT: begin
            // Loaded with CAPTURE_DLY-1, so the zero-check edge lands exactly
            // CAPTURE_DLY edges after the update edge.
            if (dly_cnt_reg == '0) begin
               capture    = 1'b1;
               state_next = IDLE;
            end else begin
               dly_cnt_next = dly_cnt_reg - DLY_W'(1);
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         dly_cnt_reg   <= '0;
         shift_cnt_reg <= '0;
         par_out_reg   <= '0;
         upd_pulse_reg <= 1'b0;
         short_err_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         dly_cnt_reg   <= dly_cnt_next;
         upd_pulse_reg <= update;

         if (update) begin
            par_out_reg   <= din_shr;
            short_err_reg <= (32'(shift_cnt_reg) < DIN_W);
            shift_cnt_reg <= '0;
         end else if (shift_en && (shift_cnt_reg != '1)) begin
            shift_cnt_reg <= shift_cnt_reg + 1'b1;
         end
      end
   end

`ifdef SERIAL_IO_BRIDGE_FRAME_CNT_EN
   logic [CNT_W-1:0] frame_cnt_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt_reg <= '0;
      end else if (capture) begin
         frame_cnt_reg <= frame_cnt_reg + 1'b1;
      end
   end

   assign frame_cnt = frame_cnt_reg;
`endif

   assign dout      = dout_shr[DOUT_W-1];
   assign par_out   = par_out_reg;
   assign busy      = (state_reg == WAIT);
   assign upd_pulse = upd_pulse_reg;
   assign short_err = short_err_reg;

endmodule

// File: tb/tb_serial_io_bridge.sv
// -----------------------------------------------------------------------------
// tb_serial_io_bridge
// Self-checking bench: one bridge with CAPTURE_DLY=2 (dut) and one in legacy
// mode CAPTURE_DLY=0 (dut0), both DIN_W=4, DOUT_W=6, CNT_W=4.
// -----------------------------------------------------------------------------
module tb_serial_io_bridge;

   localparam int DIN_W  = 4;
   localparam int DOUT_W = 6;
   localparam int CNT_W  = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   // dut (CAPTURE_DLY = 2)
   logic              din    = 1'b0;
   logic              stb    = 1'b0;
   logic [DOUT_W-1:0] par_in = '0;
   logic              dout, busy, upd_pulse, short_err;
   logic [DIN_W-1:0]  par_out;

   // dut0 (CAPTURE_DLY = 0)
   logic              din0    = 1'b0;
   logic              stb0    = 1'b0;
   logic [DOUT_W-1:0] par_in0 = '0;
   logic              dout0, busy0, upd_pulse0, short_err0;
   logic [DIN_W-1:0]  par_out0;

`ifdef SERIAL_IO_BRIDGE_FRAME_CNT_EN
   logic [CNT_W-1:0]  frame_cnt, frame_cnt0;
`endif

   int checks = 0;
   int errors = 0;

   // Bench model of dut's shift chains and expected-bit scoreboards.
   logic [DIN_W-1:0]  model_din  = '0;
   logic [DOUT_W-1:0] model_dout = '0;
   logic              exp_q[$];
   logic              exp_q0[$];

   always #5 clk = ~clk;

   serial_io_bridge #(
      .DIN_W(DIN_W), .DOUT_W(DOUT_W), .CAPTURE_DLY(2), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .din(din), .stb(stb), .dout(dout),
      .par_out(par_out), .par_in(par_in), .busy(busy),
      .upd_pulse(upd_pulse), .short_err(short_err)
`ifdef SERIAL_IO_BRIDGE_FRAME_CNT_EN
      , .frame_cnt(frame_cnt)
`endif
   );

   serial_io_bridge #(
      .DIN_W(DIN_W), .DOUT_W(DOUT_W), .CAPTURE_DLY(0), .CNT_W(CNT_W)
   ) dut0 (
      .clk(clk), .rst(rst), .din(din0), .stb(stb0), .dout(dout0),
      .par_out(par_out0), .par_in(par_in0), .busy(busy0),
      .upd_pulse(upd_pulse0), .short_err(short_err0)
`ifdef SERIAL_IO_BRIDGE_FRAME_CNT_EN
      , .frame_cnt(frame_cnt0)
`endif
   );

   // ---------------------------------------------------------------- helpers
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic shift_bit(input logic b);
      din = b;
      stb = 1'b0;
      step();
      model_dout = {model_dout[DOUT_W-2:0], model_din[DIN_W-1]};
      model_din  = {model_din[DIN_W-2:0], b};
   endtask

   task automatic shift_bit0(input logic b);
      din0 = b;
      stb0 = 1'b0;
      step();
   endtask

   task automatic push_frame(input logic [DOUT_W-1:0] v);
      for (int i = DOUT_W - 1; i >= 0; i--) exp_q.push_back(v[i]);
   endtask

   task automatic push_frame0(input logic [DOUT_W-1:0] v);
      for (int i = DOUT_W - 1; i >= 0; i--) exp_q0.push_back(v[i]);
   endtask

   // ------------------------------------------------------------------ tests
   task automatic test_reset();
      rst = 1'b1; din = 1'b0; stb = 1'b0;
      step();
      step();
      checks++; if (par_out !== 4'b0000) begin errors++; $display("FAIL reset_par_out: got %b want 0000", par_out); end
      checks++; if (dout !== 1'b0) begin errors++; $display("FAIL reset_dout: got %b want 0", dout); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (short_err !== 1'b0) begin errors++; $display("FAIL reset_short_err: got %b want 0", short_err); end
      checks++; if (upd_pulse !== 1'b0) begin errors++; $display("FAIL reset_upd_pulse: got %b want 0", upd_pulse); end
      checks++; if (par_out0 !== 4'b0000) begin errors++; $display("FAIL reset_par_out0: got %b want 0000", par_out0); end
`ifdef SERIAL_IO_BRIDGE_FRAME_CNT_EN
      checks++; if (frame_cnt !== 4'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
`endif
      rst = 1'b0;
      model_din  = '0;
      model_dout = '0;
      $display("test_reset: done");
   endtask

   task automatic test_frame();
      logic [3:0] pat;
      logic       e;
      pat = 4'b1011;
      for (int i = 3; i >= 0; i--) shift_bit(pat[i]);
      // Update edge; par_in deliberately differs from the value captured later.
      din = 1'b0; stb = 1'b1; par_in = 6'h11;
      step();
      checks++; if (par_out !== 4'b1011) begin errors++; $display("FAIL frame_par_out: got %b want 1011", par_out); end
      checks++; if (short_err !== 1'b0) begin errors++; $display("FAIL frame_short_err: got %b want 0", short_err); end
      checks++; if (upd_pulse !== 1'b1) begin errors++; $display("FAIL frame_upd_pulse: got %b want 1", upd_pulse); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL frame_busy1: got %b want 1", busy); end
      checks++; if (dout !== model_dout[DOUT_W-1]) begin errors++; $display("FAIL frame_dout_hold: got %b want %b", dout, model_dout[DOUT_W-1]); end
      stb = 1'b0;
      step();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL frame_busy2: got %b want 1", busy); end
      checks++; if (upd_pulse !== 1'b0) begin errors++; $display("FAIL frame_upd_pulse_low: got %b want 0", upd_pulse); end
      par_in = 6'h2A;
      push_frame(6'h2A);
      step();
      model_dout = 6'h2A;
      par_in = 6'h00;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frame_busy_end: got %b want 0", busy); end
      for (int i = 0; i < DOUT_W; i++) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++; $display("FAIL frame_readout_%0d: scoreboard empty", i);
         end else begin
            e = exp_q.pop_front();
            if (dout !== e) begin errors++; $display("FAIL frame_readout_%0d: got %b want %b", i, dout, e); end
         end
         shift_bit(1'b0);
      end
      $display("test_frame: done");
   endtask

   task automatic test_short();
      // Clear the shift count with an update, then let the sequence finish.
      stb = 1'b1; step(); stb = 1'b0; step(); step();
      model_dout = par_in;
      shift_bit(1'b1);
      shift_bit(1'b1);
      stb = 1'b1;
      step();
      checks++; if (short_err !== 1'b1) begin errors++; $display("FAIL short_err_set: got %b want 1", short_err); end
      checks++; if (par_out !== model_din) begin errors++; $display("FAIL short_par_out: got %b want %b", par_out, model_din); end
      stb = 1'b0; step(); step();
      model_dout = par_in;
      shift_bit(1'b0); shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b0);
      stb = 1'b1;
      step();
      checks++; if (short_err !== 1'b0) begin errors++; $display("FAIL short_err_clear: got %b want 0", short_err); end
      checks++; if (par_out !== 4'b0110) begin errors++; $display("FAIL short_par_out_full: got %b want 0110", par_out); end
      stb = 1'b0; step(); step();
      model_dout = par_in;
      $display("test_short: done");
   endtask

   task automatic test_wait_ignore();
      shift_bit(1'b1); shift_bit(1'b0); shift_bit(1'b0); shift_bit(1'b1);
      par_in = 6'h3C;
      stb = 1'b1;
      step();
      // Hammer din/stb while busy.
      din = 1'b1; stb = 1'b1;
      step();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wait_busy: got %b want 1", busy); end
      checks++; if (upd_pulse !== 1'b0) begin errors++; $display("FAIL wait_no_retrigger1: got %b want 0", upd_pulse); end
      checks++; if (dout !== model_dout[DOUT_W-1]) begin errors++; $display("FAIL wait_dout_hold: got %b want %b", dout, model_dout[DOUT_W-1]); end
      din = 1'b0; stb = 1'b1;
      step();
      model_dout = 6'h3C;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wait_busy_end: got %b want 0", busy); end
      checks++; if (upd_pulse !== 1'b0) begin errors++; $display("FAIL wait_no_retrigger2: got %b want 0", upd_pulse); end
      checks++; if (par_out !== 4'b1001) begin errors++; $display("FAIL wait_par_out: got %b want 1001", par_out); end
      checks++; if (dout !== model_dout[DOUT_W-1]) begin errors++; $display("FAIL wait_capture_dout: got %b want %b", dout, model_dout[DOUT_W-1]); end
      // Fresh update with no shifts: din_shr must still hold 1001.
      par_in = 6'h00; stb = 1'b1;
      step();
      checks++; if (par_out !== 4'b1001) begin errors++; $display("FAIL wait_din_shr_kept: got %b want 1001", par_out); end
      checks++; if (short_err !== 1'b1) begin errors++; $display("FAIL wait_zero_shift_short: got %b want 1", short_err); end
      stb = 1'b0; step(); step();
      model_dout = par_in;
      $display("test_wait_ignore: done");
   endtask

   task automatic test_reset_abort();
      shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b1);
      par_in = 6'h3F; stb = 1'b1;
      step();
      stb = 1'b0; rst = 1'b1;
      step();
      rst = 1'b0;
      model_din = '0; model_dout = '0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
      checks++; if (dout !== 1'b0) begin errors++; $display("FAIL abort_dout: got %b want 0", dout); end
      checks++; if (par_out !== 4'b0000) begin errors++; $display("FAIL abort_par_out: got %b want 0000", par_out); end
      checks++; if (upd_pulse !== 1'b0) begin errors++; $display("FAIL abort_upd_pulse: got %b want 0", upd_pulse); end
`ifdef SERIAL_IO_BRIDGE_FRAME_CNT_EN
      checks++; if (frame_cnt !== 4'd0) begin errors++; $display("FAIL abort_frame_cnt: got %0d want 0", frame_cnt); end
`endif
      for (int i = 0; i < 3; i++) begin
         shift_bit(1'b0);
         checks++; if (dout !== model_dout[DOUT_W-1]) begin errors++; $display("FAIL abort_no_late_capture_%0d: got %b want %b", i, dout, model_dout[DOUT_W-1]); end
      end
      par_in = 6'h00;
      $display("test_reset_abort: done");
   endtask

   task automatic test_nodelay();
      logic e;
      shift_bit0(1'b0); shift_bit0(1'b1); shift_bit0(1'b0); shift_bit0(1'b1);
      stb0 = 1'b1; par_in0 = 6'h15;
      push_frame0(6'h15);
      step();
      stb0 = 1'b0; par_in0 = 6'h00;
      checks++; if (par_out0 !== 4'b0101) begin errors++; $display("FAIL nodly_par_out: got %b want 0101", par_out0); end
      checks++; if (upd_pulse0 !== 1'b1) begin errors++; $display("FAIL nodly_upd_pulse: got %b want 1", upd_pulse0); end
      checks++; if (short_err0 !== 1'b0) begin errors++; $display("FAIL nodly_short_err: got %b want 0", short_err0); end
      for (int i = 0; i < DOUT_W; i++) begin
         checks++;
         if (exp_q0.size() == 0) begin
            errors++; $display("FAIL nodly_readout_%0d: scoreboard empty", i);
         end else begin
            e = exp_q0.pop_front();
            if (dout0 !== e || busy0 !== 1'b0) begin errors++; $display("FAIL nodly_readout_%0d: got dout %b busy %b want dout %b busy 0", i, dout0, busy0, e); end
         end
         shift_bit0(1'b0);
      end
`ifdef SERIAL_IO_BRIDGE_FRAME_CNT_EN
      for (int i = 0; i < 14; i++) begin
         stb0 = 1'b1; step(); stb0 = 1'b0; step();
      end
      checks++; if (frame_cnt0 !== 4'd15) begin errors++; $display("FAIL nodly_frame_cnt15: got %0d want 15", frame_cnt0); end
      stb0 = 1'b1; step(); stb0 = 1'b0; step();
      checks++; if (frame_cnt0 !== 4'd0) begin errors++; $display("FAIL nodly_frame_cnt_wrap: got %0d want 0", frame_cnt0); end
`endif
      $display("test_nodelay: done");
   endtask

   task automatic test_back_to_back();
      logic [DOUT_W-1:0] vals [3];
      logic e;
      vals[0] = 6'h20; vals[1] = 6'h00; vals[2] = 6'h3F;
      stb0 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         par_in0 = vals[i];
         exp_q0.push_back(vals[i][DOUT_W-1]);
         step();
         e = exp_q0.pop_front();
         checks++;
         if (dout0 !== e || upd_pulse0 !== 1'b1 || busy0 !== 1'b0) begin
            errors++; $display("FAIL b2b_%0d: got dout %b upd %b busy %b want dout %b upd 1 busy 0", i, dout0, upd_pulse0, busy0, e);
         end
      end
      stb0 = 1'b0; par_in0 = 6'h00;
      step();
      checks++; if (upd_pulse0 !== 1'b0) begin errors++; $display("FAIL b2b_pulse_end: got %b want 0", upd_pulse0); end
      $display("test_back_to_back: done");
   endtask

   // ------------------------------------------------------------------ main
   initial begin
      test_reset();
      test_frame();
      test_short();
      test_wait_ignore();
      test_reset_abort();
      test_nodelay();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
